rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Initiator side of the register file write port; the register file is the responder.
- Accepts writeback requests from the execute stage over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register file's write_en/regw/dataw port.
- Forwards pending (not yet committed) data to the two decode-stage read ports so decode never sees stale register-file contents.

Parameters:
REG_ADDR_WIDTH, 4, register address width (NUM_REGS = 2**REG_ADDR_WIDTH)
DATA_WIDTH, 8, register data width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  execute-stage writeback request valid
wb_ready  out  1  queue can accept request this cycle
wb_reg  in  REG_ADDR_WIDTH  destination register
wb_data  in  DATA_WIDTH  write data
drain_en  in  1  register file write port available this cycle
rf_write_en  out  1  to register file write_en
rf_regw  out  REG_ADDR_WIDTH  to register file regw
rf_dataw  out  DATA_WIDTH  to register file dataw
rd_reg1  in  REG_ADDR_WIDTH  decode read address 1 (also drives register file reg1)
rd_reg2  in  REG_ADDR_WIDTH  decode read address 2 (also drives register file reg2)
rf_data1  in  DATA_WIDTH  register file data1 (combinational read)
rf_data2  in  DATA_WIDTH  register file data2
op_data1  out  DATA_WIDTH  forwarded operand 1
op_data2  out  DATA_WIDTH  forwarded operand 2
fwd_hit1  out  1  op_data1 came from queue
fwd_hit2  out  1  op_data2 came from queue
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer of DEPTH {reg, data} entries, head/tail pointers with wrap, occupancy counter.
- Reset (rst=1 at posedge):
  - count=0, head=tail=0, all entry valid bits cleared.
  - Outputs after reset: rf_write_en=0, wb_ready=1, fwd_hit1/2=0, op_data1/2 = rf_data1/2.
  - Reset mid-operation discards all pending entries; nothing further is written to the register file.
- Pop:
  - rf_write_en = drain_en && count!=0; rf_regw/rf_dataw = head entry.
  - Outputs are combinational from head registers only; no input-to-output path.
  - When rf_write_en=1, head advances at the posedge at which the register file commits the write.
  - When count==0, rf_regw/rf_dataw hold the last head-slot contents and are don't-care.
- Push:
  - Transfer occurs when wb_valid && wb_ready at posedge; the entry is written at tail and tail advances.
  - wb_ready = (count!=DEPTH) || rf_write_en; when full and draining, push is accepted in the same cycle.
- Simultaneous push and pop: count unchanged; both pointers advance; wrap DEPTH-1 -> 0.
- Empty queue: a push in cycle N is first visible on the write port in cycle N+1. Minimum latency request -> register file commit is 2 posedges.
- Order: strict FIFO. Two writes to the same register commit in arrival order.
- Forwarding (combinational):
  - For each read port, compare rd_regX against all valid entries, including head even while it is being written this cycle.
  - On any match, op_dataX = data of the youngest matching entry (closest to tail) and fwd_hitX=1.
  - Otherwise op_dataX = rf_dataX and fwd_hitX=0.
  - The request being pushed this cycle is not forwarded; it is visible the next cycle.
- Registers are never protected; register 0 is written like any other register.
- drain_en=0: no pop; the queue fills to DEPTH, then wb_ready=0 and wb_valid is held off by the producer.
- count always equals the number of valid entries; overflow and underflow are impossible by construction.

Decomposition:
- Shared package cpu_pkg holds REG_ADDR_WIDTH and DATA_WIDTH defaults and the typedef wb_entry_t {logic [REG_ADDR_WIDTH-1:0] reg; logic [DATA_WIDTH-1:0] data;}.
- One sub-module, rf_fwd_match: takes the entry array, valid vector, tail pointer and one read address; returns hit and data using youngest-first priority. It is instantiated twice.

Test Plan:
- Reset then idle, drain_en=1 -> rf_write_en=0, count=0, wb_ready=1, op_data1=rf_data1.
- Push {reg1, 0xFF} at cycle N with drain_en=1 -> rf_write_en=1, rf_regw=1, rf_dataw=0xFF in cycle N+1. A register-file read of reg1 returns 0xFF from cycle N+2. During cycle N+1, rd_reg1=1 gives fwd_hit1=1, op_data1=0xFF.
- drain_en=0, push {2,0xAB}, {2,0xCD}, {3,0x11}, {4,0x22} -> count=4, wb_ready=0. rd_reg1=2 gives op_data1=0xCD (youngest). rd_reg2=5 gives fwd_hit2=0.
- Full queue with drain_en=1 and wb_valid=1 {5,0x33} -> push accepted same cycle, count stays 4. Commits occur in order 2/0xAB, 2/0xCD, 3/0x11, 4/0x22, 5/0x33; pointers wrap.
- Assert rst with 3 entries pending -> next cycle count=0, rf_write_en=0, fwd_hit1/2=0. Register file contents are unchanged by the discarded entries.
- Push at an address equal to rd_reg1 in the same cycle the queue is empty -> fwd_hit1=0 that cycle; fwd_hit1=1 with the pushed data the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the writeback path.
// REG_ADDR_WIDTH / DATA_WIDTH are the default register-file geometry,
// wb_entry_t is one pending writeback {destination register, data}.
package cpu_pkg;

  localparam int REG_ADDR_WIDTH = 4;
  localparam int DATA_WIDTH     = 8;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Youngest-first forwarding lookup over the writeback queue.
// Ports:
//   ent_addr/ent_data  per-slot destination register and data
//   ent_valid          per-slot occupancy
//   tail               next write slot; tail-1 is the youngest entry
//   rd_addr            read address to match
//   hit/data           hit=1 when any valid slot matches; data from the youngest match
module rf_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = cpu_pkg::REG_ADDR_WIDTH,
  parameter int DW    = cpu_pkg::DATA_WIDTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [PW-1:0]            tail,
  input  logic [AW-1:0]            rd_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  // Slots re-indexed by age: age 0 is the youngest (tail-1), age DEPTH-1 the oldest.
  logic [PW-1:0]    age_idx   [DEPTH];
  logic [DEPTH-1:0] age_match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi]   = tail - PW'(gi + 1);
      assign age_match[gi] = ent_valid[age_idx[gi]] && (ent_addr[age_idx[gi]] == rd_addr);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the final assignment.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (age_match[k]) begin
        hit  = 1'b1;
        data = ent_data[age_idx[k]];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue between execute and the register-file write port,
// with forwarding of not-yet-committed data to the two decode read ports.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wb_valid/wb_ready/wb_reg/wb_data   execute-stage push handshake
//   drain_en                     register-file write port free this cycle
//   rf_write_en/rf_regw/rf_dataw register-file write port (head entry)
//   rd_reg1/rd_reg2              decode read addresses
//   rf_data1/rf_data2            register-file read data
//   op_data1/op_data2            operands after forwarding
//   fwd_hit1/fwd_hit2            operand taken from the queue
//   count                        occupied entries
module rf_writeback_queue #(
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int DEPTH          = 4,
  localparam int PW            = $clog2(DEPTH),
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      drain_en,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_regw,
  output logic [DATA_WIDTH-1:0]     rf_dataw,
  input  logic [REG_ADDR_WIDTH-1:0] rd_reg1,
  input  logic [REG_ADDR_WIDTH-1:0] rd_reg2,
  input  logic [DATA_WIDTH-1:0]     rf_data1,
  input  logic [DATA_WIDTH-1:0]     rf_data2,
  output logic [DATA_WIDTH-1:0]     op_data1,
  output logic [DATA_WIDTH-1:0]     op_data2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [CW-1:0]             count
);

  logic [PW-1:0]                          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [DEPTH-1:0]                       valid_q, valid_d;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]       data_q, data_d;
  logic                                   push, pop;
  logic                                   hit1, hit2;
  logic [DATA_WIDTH-1:0]                  fwd1, fwd2;

  assign rf_write_en = drain_en && (count_q != '0);
  assign pop         = rf_write_en;
  // A full queue still accepts when the head commits in the same cycle.
  assign wb_ready    = (count_q != CW'(DEPTH)) || rf_write_en;
  assign push        = wb_valid && wb_ready;

  assign rf_regw  = addr_q[head_q];
  assign rf_dataw = data_q[head_q];
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // Pop before push: when full, head and tail share a slot and the new entry must win.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = wb_reg;
      data_d[tail_q]  = wb_data;
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  rf_fwd_match #(.DEPTH(DEPTH), .AW(REG_ADDR_WIDTH), .DW(DATA_WIDTH)) u_fwd1 (
    .ent_addr (addr_q),
    .ent_data (data_q),
    .ent_valid(valid_q),
    .tail     (tail_q),
    .rd_addr  (rd_reg1),
    .hit      (hit1),
    .data     (fwd1)
  );

  rf_fwd_match #(.DEPTH(DEPTH), .AW(REG_ADDR_WIDTH), .DW(DATA_WIDTH)) u_fwd2 (
    .ent_addr (addr_q),
    .ent_data (data_q),
    .ent_valid(valid_q),
    .tail     (tail_q),
    .rd_addr  (rd_reg2),
    .hit      (hit2),
    .data     (fwd2)
  );

  assign fwd_hit1 = hit1;
  assign fwd_hit2 = hit2;
  assign op_data1 = hit1 ? fwd1 : rf_data1;
  assign op_data2 = hit2 ? fwd2 : rf_data2;

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;
  import cpu_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          drain_en = 1'b0;
  logic          rf_write_en;
  logic [AW-1:0] rf_regw;
  logic [DW-1:0] rf_dataw;
  logic [AW-1:0] rd_reg1 = '0;
  logic [AW-1:0] rd_reg2 = '0;
  logic [DW-1:0] rf_data1, rf_data2;
  logic [DW-1:0] op_data1, op_data2;
  logic          fwd_hit1, fwd_hit2;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  // Reference model: pending writes in arrival order, plus the expected register file.
  wb_entry_t     q[$];
  logic [DW-1:0] exp_rf [NREG];
  // Register file responder driven by the DUT's write port.
  logic [DW-1:0] rf_mem [NREG];

  assign rf_data1 = rf_mem[rd_reg1];
  assign rf_data2 = rf_mem[rd_reg2];

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_write_en) rf_mem[rf_regw] <= rf_dataw;

  rf_writeback_queue #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .drain_en(drain_en),
    .rf_write_en(rf_write_en), .rf_regw(rf_regw), .rf_dataw(rf_dataw),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .op_data1(op_data1), .op_data2(op_data2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .count(count)
  );

  // Apply inputs just after a posedge and let them settle before sampling.
  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                       input logic dr, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wb_valid = v; wb_reg = r; wb_data = d; drain_en = dr; rd_reg1 = r1; rd_reg2 = r2;
    #2;
  endtask

  // Step the model through one posedge using the inputs that were applied.
  task automatic advance();
    bit        pop, push;
    wb_entry_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      pop  = drain_en && (q.size() != 0);
      push = wb_valid && ((q.size() != DEPTH) || pop);
      if (pop) begin
        e = q.pop_front();
        exp_rf[e.addr] = e.data;
      end
      if (push) begin
        e.addr = wb_reg;
        e.data = wb_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  // Latest pending write to an address wins; otherwise the register file value.
  function automatic void model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = exp_rf[a];
    for (int i = 0; i < q.size(); i++)
      if (q[i].addr == a) begin
        hit = 1'b1;
        d   = q[i].data;
      end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 1, 3, 7);
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 1, 3, 7);
    total++; if (rf_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_write_en); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", wb_ready); end
    total++; if (fwd_hit1 !== 1'b0 || op_data1 !== exp_rf[3]) begin bad++;
      $display("FAIL reset_op1 got=%b/%h want=0/%h", fwd_hit1, op_data1, exp_rf[3]); end
    $display("reset: count=%0d ready=%b op1=%h", count, wb_ready, op_data1);
    advance();
  endtask

  task automatic test_single();
    drive(1, 1, 8'hFF, 1, 1, 0);
    total++; if (fwd_hit1 !== 1'b0 || rf_write_en !== 1'b0) begin bad++;
      $display("FAIL single_push_cycle got hit=%b we=%b want 0/0", fwd_hit1, rf_write_en); end
    advance();
    drive(0, 0, 0, 1, 1, 0);
    total++; if (rf_write_en !== 1'b1 || rf_regw !== 4'd1 || rf_dataw !== 8'hFF) begin bad++;
      $display("FAIL single_write got=%b/%0d/%h want=1/1/ff", rf_write_en, rf_regw, rf_dataw); end
    total++; if (fwd_hit1 !== 1'b1 || op_data1 !== 8'hFF) begin bad++;
      $display("FAIL single_fwd got=%b/%h want=1/ff", fwd_hit1, op_data1); end
    $display("single: we=%b regw=%0d dataw=%h op1=%h", rf_write_en, rf_regw, rf_dataw, op_data1);
    advance();
    drive(0, 0, 0, 1, 1, 0);
    total++; if (fwd_hit1 !== 1'b0 || op_data1 !== 8'hFF || rf_write_en !== 1'b0) begin bad++;
      $display("FAIL single_commit got=%b/%h/%b want=0/ff/0", fwd_hit1, op_data1, rf_write_en); end
    advance();
  endtask

  task automatic test_fill_and_drain();
    logic [AW-1:0] er [5] = '{4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [DW-1:0] ed [5] = '{8'hAB, 8'hCD, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      drive(1, er[i], ed[i], 0, 0, 0);
      advance();
    end
    // Producer keeps offering while full: must be refused.
    drive(1, 4'd9, 8'h99, 0, 2, 5);
    total++; if (count !== 3'd4 || wb_ready !== 1'b0) begin bad++;
      $display("FAIL full_state got=%0d/%b want=4/0", count, wb_ready); end
    total++; if (fwd_hit1 !== 1'b1 || op_data1 !== 8'hCD) begin bad++;
      $display("FAIL full_youngest got=%b/%h want=1/cd", fwd_hit1, op_data1); end
    total++; if (fwd_hit2 !== 1'b0 || op_data2 !== exp_rf[5]) begin bad++;
      $display("FAIL full_miss got=%b/%h want=0/%h", fwd_hit2, op_data2, exp_rf[5]); end
    $display("full: count=%0d ready=%b op1=%h hit2=%b", count, wb_ready, op_data1, fwd_hit2);
    advance();
    drive(1, er[4], ed[4], 1, 0, 0);
    total++; if (wb_ready !== 1'b1 || rf_write_en !== 1'b1) begin bad++;
      $display("FAIL full_drain_push got=%b/%b want=1/1", wb_ready, rf_write_en); end
    advance();
    drive(0, 0, 0, 1, 0, 0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_swap_count got=%0d want=4", count); end
    // First commit happened in the swap cycle; observe the remaining four in order.
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      total++; if (rf_write_en !== 1'b1 || rf_regw !== er[i] || rf_dataw !== ed[i]) begin bad++;
        $display("FAIL drain_order[%0d] got=%b/%0d/%h want=1/%0d/%h", i, rf_write_en, rf_regw, rf_dataw, er[i], ed[i]); end
      $display("drain: regw=%0d dataw=%h", rf_regw, rf_dataw);
      advance();
    end
    drive(0, 0, 0, 1, 0, 0);
    total++; if (count !== 3'd0 || rf_write_en !== 1'b0) begin bad++;
      $display("FAIL drain_empty got=%0d/%b want=0/0", count, rf_write_en); end
    total++; if (rf_mem[2] !== 8'hCD || rf_mem[5] !== 8'h33) begin bad++;
      $display("FAIL drain_rf got=%h/%h want=cd/33", rf_mem[2], rf_mem[5]); end
  endtask

  task automatic test_reset_mid();
    drive(1, 4'd6, 8'h61, 0, 0, 0); advance();
    drive(1, 4'd7, 8'h71, 0, 0, 0); advance();
    drive(1, 4'd8, 8'h81, 0, 0, 0); advance();
    rst = 1'b1;
    drive(0, 0, 0, 0, 6, 8);
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 1, 6, 8);
    total++; if (count !== 3'd0 || rf_write_en !== 1'b0) begin bad++;
      $display("FAIL midreset_state got=%0d/%b want=0/0", count, rf_write_en); end
    total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin bad++;
      $display("FAIL midreset_fwd got=%b/%b want=0/0", fwd_hit1, fwd_hit2); end
    $display("midreset: count=%0d we=%b", count, rf_write_en);
    advance();
    drive(0, 0, 0, 1, 6, 8);
    advance();
    for (int r = 0; r < NREG; r++) begin
      total++; if (rf_mem[r] !== exp_rf[r]) begin bad++;
        $display("FAIL midreset_rf[%0d] got=%h want=%h", r, rf_mem[r], exp_rf[r]); end
    end
  endtask

  task automatic test_random();
    logic          h1, h2, ewe, erdy;
    logic [DW-1:0] d1, d2;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 99) < 60), 4'($urandom), 8'($urandom),
            1'($urandom_range(0, 99) < 55), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      model_fwd(rd_reg1, h1, d1);
      model_fwd(rd_reg2, h2, d2);
      ewe  = drain_en && (q.size() != 0);
      erdy = (q.size() != DEPTH) || ewe;
      total++; if (rf_write_en !== ewe || wb_ready !== erdy || count !== 3'(q.size())) begin bad++;
        $display("FAIL rnd_ctrl n=%0d got we=%b rdy=%b cnt=%0d want %b/%b/%0d", n, rf_write_en, wb_ready, count, ewe, erdy, q.size()); end
      if (ewe) begin
        total++; if (rf_regw !== q[0].addr || rf_dataw !== q[0].data) begin bad++;
          $display("FAIL rnd_head n=%0d got=%0d/%h want=%0d/%h", n, rf_regw, rf_dataw, q[0].addr, q[0].data); end
      end
      total++; if (fwd_hit1 !== h1 || op_data1 !== d1 || fwd_hit2 !== h2 || op_data2 !== d2) begin bad++;
        $display("FAIL rnd_fwd n=%0d got %b/%h %b/%h want %b/%h %b/%h", n, fwd_hit1, op_data1, fwd_hit2, op_data2, h1, d1, h2, d2); end
      advance();
    end
    for (int n = 0; n < 8; n++) begin drive(0, 0, 0, 1, 0, 0); advance(); end
    for (int r = 0; r < NREG; r++) begin
      total++; if (rf_mem[r] !== exp_rf[r]) begin bad++;
        $display("FAIL rnd_rf[%0d] got=%h want=%h", r, rf_mem[r], exp_rf[r]); end
    end
    $display("random: %0d cycles, queue left=%0d", 400, q.size());
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      rf_mem[r] = 8'(r * 7 + 3);
      exp_rf[r] = 8'(r * 7 + 3);
    end
    #1;
    test_reset();
    test_single();
    test_fill_and_drain();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
